// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//
// Parametrised radix-2 shift-add sequential multiplier. Replaces the fixed
// 16x16 unsigned multiplier. It adds a generic operand width, a signed or
// unsigned mode chosen for each operation, an asynchronous reset, an explicit
// FSM with busy/ready flags, and optional early termination.
//
// Operation: the multiplier works on operand magnitudes. |a| is zero-extended
// to 2*WIDTH bits and shifted left once per cycle. |b| is shifted right once
// per cycle, and its LSB decides whether the shifted |a| is added into the
// partial sum. A final FIX cycle applies the product sign by two's-complement
// negation. The negation uses the same adder: ~partial_sum + 0 with carry-in 1.
//
// The accumulator is a ripple chain of full-adder cells, 2*WIDTH bits wide. At
// WIDTH=16 it is the 32-bit chain that the FA32 library block provides.
//
// Build option:
//   SEQ_MULT_EARLY_TERM_EN  When defined, BUSY also exits to FIX after any add
//                           that leaves no set bits in the shifted multiplier.
//                           Latency is then msb_index(|b|)+2 cycles (2 when
//                           |b|=0), and never more than WIDTH+1. Result values
//                           do not change. When undefined, every operation
//                           takes WIDTH+1 cycles.
//
// Parameters:
//   WIDTH        operand width in bits (>= 2); the product is 2*WIDTH bits
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset; overrides start
//   start        synchronous start/restart, sampled on clk posedge
//   signed_mode  1 = operands are two's complement, 0 = unsigned (taken with start)
//   a            multiplicand (taken with start)
//   b            multiplier (taken with start)
//   busy         high while an operation is in progress
//   ready        high when result holds a finished product
//   result       2*WIDTH-bit product, held until the next start or reset
// -----------------------------------------------------------------------------
module seq_mult_param #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;          // product width
  localparam int CW = $clog2(WIDTH);      // counter width; counts 0..WIDTH-1

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state;
  logic [PW-1:0]   reg_a;        // shifted multiplicand magnitude
  logic [WIDTH-1:0] reg_b;       // shifted multiplier magnitude
  logic [PW-1:0]   partial_sum;
  logic [CW-1:0]   count;        // index of the add performed on this edge
  logic            neg;          // product must be negated in FIX

  // ---------------------------------------------------------------------------
  // Magnitude of an operand. In signed mode the most negative value
  // -2^(WIDTH-1) negates to its own bit pattern. Read as unsigned, that pattern
  // is the correct magnitude 2^(WIDTH-1), so no extra bit is needed.
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             sm);
    magnitude = (sm && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // ---------------------------------------------------------------------------
  // Shared ripple-carry adder. BUSY accumulates the gated multiplicand. FIX
  // forms -partial_sum as ~partial_sum + 0 + carry-in. The carry out of the
  // top bit is dropped because the arithmetic is modulo 2^(2*WIDTH).
  // ---------------------------------------------------------------------------
  logic [PW-1:0] add_x;
  logic [PW-1:0] add_y;
  logic          add_cin;
  logic [PW-1:0] add_s;
  logic [PW-1:0] carry;

  // NOTE: every signal written in this block gets a default before any branch.
  // Without the defaults, a path that skips an assignment would infer a latch.
  always_comb begin
    add_x   = partial_sum;
    add_y   = '0;
    add_cin = 1'b0;
    if (state == S_FIX) begin
      add_x   = ~partial_sum;
      add_cin = 1'b1;
    end else if (reg_b[0]) begin
      add_y = reg_a;
    end
  end

  assign carry[0] = add_cin;

  for (genvar i = 0; i < PW; i++) begin : g_fa
    // Full-adder cell i of the ripple chain.
    assign add_s[i] = add_x[i] ^ add_y[i] ^ carry[i];
    if (i < PW - 1) begin : g_carry
      assign carry[i+1] = (add_x[i] & add_y[i]) | (carry[i] & (add_x[i] ^ add_y[i]));
    end
  end

  // ---------------------------------------------------------------------------
  // Exit condition for BUSY, evaluated for the add that happens on this edge.
  // ---------------------------------------------------------------------------
  logic last_add;

`ifdef SEQ_MULT_EARLY_TERM_EN
  // Leave BUSY once the bits that remain above reg_b[0] are all zero. Later
  // adds would only add zero, so skipping them leaves the product unchanged.
  assign last_add = (count == CW'(WIDTH - 1)) || (reg_b[WIDTH-1:1] == '0);
`else
  assign last_add = (count == CW'(WIDTH - 1));
`endif

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers. All outputs are registered. start is
  // accepted in every state: a start during BUSY or FIX discards the
  // operation in flight.
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments only. Every register
  // then sees the pre-edge values of the others, so the result does not depend
  // on statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: every register is cleared, including the datapath. After reset,
      // result reads 0 and no stale operands can leak into the next run.
      state       <= S_IDLE;
      busy        <= 1'b0;
      ready       <= 1'b0;
      result      <= '0;
      reg_a       <= '0;
      reg_b       <= '0;
      partial_sum <= '0;
      count       <= '0;
      neg         <= 1'b0;
    end else if (start) begin
      reg_a       <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
      reg_b       <= magnitude(b, signed_mode);
      neg         <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      partial_sum <= '0;
      count       <= '0;
      ready       <= 1'b0;
      busy        <= 1'b1;
      state       <= S_BUSY;
    end else begin
      case (state)
        S_BUSY: begin
          partial_sum <= add_s;
          reg_a       <= reg_a << 1;
          reg_b       <= reg_b >> 1;
          count       <= count + CW'(1);
          if (last_add) begin
            state <= S_FIX;
          end
        end

        S_FIX: begin
          // add_s carries -partial_sum in this state.
          result <= neg ? add_s : partial_sum;
          ready  <= 1'b1;
          busy   <= 1'b0;
          state  <= S_DONE;
        end

        default: begin
          // IDLE and DONE keep result, ready and busy unchanged.
        end
      endcase
    end
  end

endmodule
